// File: rtl/hilo_muldiv_unit_if.sv
// Command and result bundle between the control/datapath and the HI/LO multiply-divide unit.
// The core drives the command signals and reads back HI/LO plus the busy/done status.
interface hilo_muldiv_unit_if;
    logic        start;
    logic        flush;
    logic        hi_write;
    logic        lo_write;
    logic        if_unsigned;
    logic [3:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, flush, hi_write, lo_write, if_unsigned, alu_op, rs_data, rt_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, flush, hi_write, lo_write, if_unsigned, alu_op, rs_data, rt_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// It does one bit per cycle on magnitudes and fixes the result signs in a final cycle.
module hilo_muldiv_unit (
    input  logic                 clk,
    input  logic                 rst_n,
    hilo_muldiv_unit_if.slave    bus
);

    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // MUL: running product. DIV: {partial remainder, dividend shifting into quotient}.
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic        cmd_mul, cmd_div, cmd_mthi, cmd_mtlo;
    logic [31:0] rs_abs, rt_abs;
    logic [32:0] mul_sum;
    logic [31:0] div_trial;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] prod_neg;
    logic [31:0] rem_neg, quo_neg;

    assign is_signed = ~bus.if_unsigned;
    assign cmd_mul   = bus.hi_write & bus.lo_write & (bus.alu_op == ALU_MUL);
    assign cmd_div   = bus.hi_write & bus.lo_write & (bus.alu_op == ALU_DIV);
    assign cmd_mthi  = bus.hi_write & ~bus.lo_write;
    assign cmd_mtlo  = bus.lo_write & ~bus.hi_write;

    assign rs_abs = (is_signed & bus.rs_data[31]) ? (32'd0 - bus.rs_data) : bus.rs_data;
    assign rt_abs = (is_signed & bus.rt_data[31]) ? (32'd0 - bus.rt_data) : bus.rt_data;

    assign mul_sum = {1'b0, acc_q[63:32]} + ({33{acc_q[0]}} & {1'b0, opb_q});

    // The shifted partial remainder is 33 bits wide: acc_q[63] is its top bit, so any
    // set top bit guarantees it exceeds the 32-bit divisor and the low 32 bits of the
    // difference are exact.
    assign div_trial = {acc_q[62:32], acc_q[31]};
    assign div_ge    = acc_q[63] | (div_trial >= opb_q);
    assign div_sub   = div_trial - opb_q;

    assign prod_neg = 64'd0 - acc_q;
    assign rem_neg  = 32'd0 - acc_q[63:32];
    assign quo_neg  = 32'd0 - acc_q[31:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (cmd_mul || cmd_div) begin
                            neg_lo_d = is_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
                            neg_hi_d = is_signed & bus.rs_data[31];
                            is_div_d = cmd_div;
                            cnt_d    = 5'd0;
                            if (cmd_mul) begin
                                acc_d   = {32'd0, rt_abs};
                                opb_d   = rs_abs;
                                state_d = StMul;
                            end else if (bus.rt_data == 32'd0) begin
                                // Divide by zero: raw dividend to HI, all-ones to LO, no sign fix.
                                acc_d    = {bus.rs_data, 32'hFFFF_FFFF};
                                opb_d    = 32'd0;
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                                state_d  = StFix;
                            end else begin
                                acc_d   = {32'd0, rs_abs};
                                opb_d   = rt_abs;
                                state_d = StDiv;
                            end
                        end else if (cmd_mthi) begin
                            hi_d = bus.rs_data;
                        end else if (cmd_mtlo) begin
                            lo_d = bus.rs_data;
                        end
                    end
                end
                StMul: begin
                    acc_d = {mul_sum, acc_q[31:1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StFix;
                    end
                end
                StDiv: begin
                    if (div_ge) begin
                        acc_d = {div_sub, acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {div_trial, acc_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_d = neg_hi_q ? rem_neg : acc_q[63:32];
                        lo_d = neg_lo_q ? quo_neg : acc_q[31:0];
                    end else begin
                        hi_d = neg_lo_q ? prod_neg[63:32] : acc_q[63:32];
                        lo_d = neg_lo_q ? prod_neg[31:0]  : acc_q[31:0];
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;

endmodule
